// File: rtl/pixel_downsample_binarize.sv
// pixel_downsample_binarize
// Takes the RGB565 pixel stream from the capture stage and crops a centred square ROI.
// Each ROI pixel is thresholded to dark or light, and each CELL x CELL block is majority-voted
// into one bit. The resulting GRID x GRID ink image is written to the classifier's image buffer.
module pixel_downsample_binarize #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int CELL   = 8,
  parameter int GRID   = 28,
  parameter int X0     = 48,
  parameter int Y0     = 8,
  parameter int THRESH = 48,
  parameter int MAJ    = 32
) (
  input  logic        p_clock,
  input  logic        reset,
  input  logic        pixel_valid,
  input  logic [15:0] pixel_data,
  input  logic        frame_done,
  output logic        cell_wr_en,
  output logic [9:0]  cell_addr,
  output logic        cell_bit,
  output logic        digit_done,
  output logic        busy
);

  localparam int ROI       = GRID * CELL;
  localparam int CELL_BITS = $clog2(CELL);
  localparam int IDX_W     = $clog2(GRID);

  localparam logic [8:0] COL_LO   = 9'(X0);
  localparam logic [8:0] COL_HI   = 9'(X0 + ROI);
  localparam logic [8:0] COL_LAST = 9'(IMG_W - 1);
  localparam logic [7:0] ROW_LO   = 8'(Y0);
  localparam logic [7:0] ROW_HI   = 8'(Y0 + ROI);
  localparam logic [7:0] ROW_END  = 8'(IMG_H);
  localparam logic [9:0] LAST_ADDR = 10'(GRID * GRID - 1);

  typedef enum logic [1:0] {SYNC, ACTIVE, DRAIN} state_t;

  state_t state, state_next;

  logic [8:0] col;
  logic [7:0] row;
  logic [6:0] acc [GRID];

  logic [6:0]       gray;
  logic             dark;
  logic             accept;
  logic             in_roi;
  logic [8:0]       rel_col;
  logic [7:0]       rel_row;
  logic [IDX_W-1:0] cc;
  logic [IDX_W-1:0] cr;
  logic             cell_close;
  logic [7:0]       acc_sum;
  logic [9:0]       addr_calc;
  logic             last_write;

  // Pixel classification, ROI position and cell-close detection for the current pixel
  always_comb begin
    gray       = {2'b00, pixel_data[15:11]} + {1'b0, pixel_data[10:5]} + {2'b00, pixel_data[4:0]};
    dark       = (gray < 7'(THRESH));
    accept     = pixel_valid && !frame_done && (state == ACTIVE) && (row < ROW_END);
    in_roi     = (col >= COL_LO) && (col < COL_HI) && (row >= ROW_LO) && (row < ROW_HI);
    rel_col    = col - COL_LO;
    rel_row    = row - ROW_LO;
    cc         = rel_col[CELL_BITS +: IDX_W];
    cr         = rel_row[CELL_BITS +: IDX_W];
    cell_close = accept && in_roi && (&rel_col[CELL_BITS-1:0]) && (&rel_row[CELL_BITS-1:0]);
    acc_sum    = {1'b0, acc[cc]} + 8'(dark);
    addr_calc  = 10'(cr) * 10'(GRID) + 10'(cc);
    last_write = (state == ACTIVE) && cell_wr_en && (cell_addr == LAST_ADDR);
  end

  // State register
  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) state <= SYNC;
    else       state <= state_next;
  end

  // Next-state logic; a frame_done in ACTIVE restarts the frame instead of finishing it
  always_comb begin
    state_next = state;
    busy       = (state == ACTIVE);
    case (state)
      SYNC:    if (frame_done) state_next = ACTIVE;
      ACTIVE:  if (!frame_done && last_write) state_next = DRAIN;
      DRAIN:   if (frame_done) state_next = ACTIVE;
      default: state_next = SYNC;
    endcase
  end

  // Column/row counters and per-column-of-cells dark accumulators; frame_done restarts them
  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      for (int i = 0; i < GRID; i++) acc[i] <= '0;
    end else if (frame_done) begin
      col <= '0;
      row <= '0;
      for (int i = 0; i < GRID; i++) acc[i] <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 8'd1;
      end else begin
        col <= col + 9'd1;
      end
      if (in_roi) begin
        if (cell_close) acc[cc] <= '0;
        else            acc[cc] <= acc[cc] + 7'(dark);
      end
    end
  end

  // Registered buffer write one cycle after each closing pixel, then the completion pulse
  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) begin
      cell_wr_en <= 1'b0;
      cell_addr  <= '0;
      cell_bit   <= 1'b0;
      digit_done <= 1'b0;
    end else begin
      cell_wr_en <= cell_close;
      digit_done <= last_write;
      if (cell_close) begin
        cell_addr <= addr_calc;
        cell_bit  <= (acc_sum >= 8'(MAJ));
      end
    end
  end

endmodule

// File: tb/tb_pixel_downsample_binarize.sv
// tb_pixel_downsample_binarize
// Directed frames drive the pixel stream; expected buffer writes are queued as closing pixels
// are issued and a separate monitor pops and compares every write the DUT presents.
module tb_pixel_downsample_binarize;

  logic        p_clock = 1'b0;
  logic        reset;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic        frame_done;
  logic        cell_wr_en;
  logic [9:0]  cell_addr;
  logic        cell_bit;
  logic        digit_done;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  int dd_seen    = 0;
  logic prev_last = 1'b0;
  logic [10:0] exp_q [$];
  logic [10:0] exp_item;

  pixel_downsample_binarize dut (
    .p_clock     (p_clock),
    .reset       (reset),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .frame_done  (frame_done),
    .cell_wr_en  (cell_wr_en),
    .cell_addr   (cell_addr),
    .cell_bit    (cell_bit),
    .digit_done  (digit_done),
    .busy        (busy)
  );

  // Free-running pixel clock
  always #5 p_clock = ~p_clock;

  task automatic check_output(input string name, input int actual, input int required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  // One clock of stimulus; strobes drop again right after the sampling edge
  task automatic apply_stimulus(input logic v, input logic [15:0] d, input logic fd);
    pixel_valid = v;
    pixel_data  = d;
    frame_done  = fd;
    @(posedge p_clock);
    #1;
    pixel_valid = 1'b0;
    frame_done  = 1'b0;
  endtask

  // Queue the expected write if this pixel closes a cell of the ROI
  task automatic push_if_close(input int col, input int row, input logic b);
    if (col >= 48 && col < 272 && row >= 8 && row < 232 &&
        ((col - 48) % 8) == 7 && ((row - 8) % 8) == 7)
      exp_q.push_back({10'(((row - 8) / 8) * 28 + (col - 48) / 8), b});
  endtask

  // Cell-threshold frame: cell 0 has 32 dark, cell 1 has 31 dark, cell 2 all 0x8200,
  // cell 3 all 0x8410, cell 4 has 32 of 0x8200, cell 5 has 33 dark; everything else light
  function automatic logic [15:0] small_pix(input int col, input int row);
    int cc;
    int k;
    if (row < 8 || row > 15 || col < 48 || col >= 272) return 16'h0000;
    cc = (col - 48) / 8;
    k  = (row - 8) * 8 + (col - 48) % 8;
    case (cc)
      0:       return (k < 32) ? 16'h0000 : 16'hFFFF;
      1:       return (k < 31) ? 16'h0000 : 16'hFFFF;
      2:       return 16'h8200;
      3:       return 16'h8410;
      4:       return (k < 32) ? 16'h8200 : 16'h8410;
      5:       return (k < 33) ? 16'h0000 : 16'hFFFF;
      default: return 16'hFFFF;
    endcase
  endfunction

  function automatic logic small_bit(input int cc);
    return (cc == 0) || (cc == 2) || (cc == 4) || (cc == 5);
  endfunction

  // Full frame: ROI cells form a checkerboard, cell (cr,cc) inked when cr+cc is even
  function automatic logic [15:0] full_pix(input int col, input int row);
    if (row < 8 || row >= 232 || col < 48 || col >= 272) return 16'h0000;
    return ((((row - 8) / 8 + (col - 48) / 8) % 2) == 0) ? 16'h0000 : 16'hFFFF;
  endfunction

  // Monitor: pops the scoreboard on every write and ties digit_done to the write of cell 783
  always @(negedge p_clock) begin
    if (reset) begin
      prev_last = 1'b0;
    end else begin
      if (digit_done) begin
        dd_seen++;
        check_output("digit_done_after_783", int'(prev_last), 1);
      end
      if (cell_wr_en) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_write: got addr %0d bit %0d, expected no write", cell_addr, cell_bit);
        end else begin
          exp_item = exp_q.pop_front();
          check_output("write_addr", int'(cell_addr), int'(exp_item[10:1]));
          check_output("write_bit", int'(cell_bit), int'(exp_item[0]));
        end
      end
      prev_last = cell_wr_en && (cell_addr == 10'd783);
    end
  end

  initial begin
    reset       = 1'b1;
    pixel_valid = 1'b0;
    frame_done  = 1'b0;
    pixel_data  = 16'h0000;
    repeat (2) @(posedge p_clock);
    #1;
    check_output("reset_wr_en", int'(cell_wr_en), 0);
    check_output("reset_addr", int'(cell_addr), 0);
    check_output("reset_bit", int'(cell_bit), 0);
    check_output("reset_digit_done", int'(digit_done), 0);
    check_output("reset_busy", int'(busy), 0);
    reset = 1'b0;
    apply_stimulus(1'b0, 16'h0000, 1'b0);

    // Pixels before the first frame_done are ignored
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 16'h0000, 1'b0);
    check_output("sync_busy", int'(busy), 0);

    // frame_done together with a pixel: the pixel must be discarded
    apply_stimulus(1'b1, 16'h0000, 1'b1);
    check_output("active_busy", int'(busy), 1);

    // Short frame of 16 rows exercising cell thresholds, with gaps in pixel_valid
    for (int row = 0; row < 16; row++) begin
      for (int col = 0; col < 320; col++) begin
        if ((col % 13) == 5) apply_stimulus(1'b0, 16'h0000, 1'b0);
        push_if_close(col, row, small_bit((col - 48) / 8));
        apply_stimulus(1'b1, small_pix(col, row), 1'b0);
      end
    end
    repeat (3) apply_stimulus(1'b0, 16'h0000, 1'b0);
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("short_frame_no_done", dd_seen, 0);
    check_output("short_frame_busy", int'(busy), 1);

    // Light 16-row frame, then reset while cell_addr holds 27 and the block is busy
    for (int row = 0; row < 16; row++) begin
      for (int col = 0; col < 320; col++) begin
        push_if_close(col, row, 1'b0);
        apply_stimulus(1'b1, 16'hFFFF, 1'b0);
      end
    end
    repeat (3) apply_stimulus(1'b0, 16'h0000, 1'b0);
    reset = 1'b1;
    #1;
    check_output("midreset_wr_en", int'(cell_wr_en), 0);
    check_output("midreset_addr", int'(cell_addr), 0);
    check_output("midreset_bit", int'(cell_bit), 0);
    check_output("midreset_digit_done", int'(digit_done), 0);
    check_output("midreset_busy", int'(busy), 0);
    repeat (2) @(posedge p_clock);
    #1;
    reset = 1'b0;

    // After reset the block waits for frame_done: these dark rows must produce no writes
    for (int i = 0; i < 16 * 320; i++) apply_stimulus(1'b1, 16'h0000, 1'b0);
    check_output("post_reset_busy", int'(busy), 0);
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("post_reset_active", int'(busy), 1);

    // Full checkerboard frame up to the pixel that closes cell 783
    for (int row = 0; row < 232; row++) begin
      for (int col = 0; col < ((row == 231) ? 272 : 320); col++) begin
        push_if_close(col, row, ((((row - 8) / 8 + (col - 48) / 8) % 2) == 0));
        apply_stimulus(1'b1, full_pix(col, row), 1'b0);
      end
    end
    repeat (3) apply_stimulus(1'b0, 16'h0000, 1'b0);
    check_output("full_frame_digit_done", dd_seen, 1);
    check_output("drain_busy", int'(busy), 0);
    check_output("queue_empty", exp_q.size(), 0);

    // Remaining pixels of the row are ignored in DRAIN; frame_done rearms the block
    for (int i = 0; i < 48; i++) apply_stimulus(1'b1, 16'h0000, 1'b0);
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_output("rearm_busy", int'(busy), 1);
    repeat (3) apply_stimulus(1'b0, 16'h0000, 1'b0);
    check_output("final_digit_done_count", dd_seen, 1);
    check_output("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
